// File: rtl/register_file.sv
// Architectural register file: 15 storage registers plus a PC alias at the top
// address, three combinational read ports and one synchronous write port.
module regfile_rd_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] bank,
    input  logic [ADDR_WIDTH-1:0]                    addr,
    output logic [DATA_WIDTH-1:0]                    data
);
    assign data = bank[addr];
endmodule

module register_file #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    input  logic [ADDR_WIDTH-1:0] RC,
    input  logic [ADDR_WIDTH-1:0] RW,
    input  logic [DATA_WIDTH-1:0] PW,
    input  logic                  LE,
    input  logic [DATA_WIDTH-1:0] PROGCOUNT,
    output logic [DATA_WIDTH-1:0] PA,
    output logic [DATA_WIDTH-1:0] PB,
    output logic [DATA_WIDTH-1:0] PC
);
    localparam int NREG   = 2**ADDR_WIDTH;
    localparam int NSTORE = NREG - 1;
    localparam int NPORTS = 3;

    logic [NSTORE-1:0][DATA_WIDTH-1:0] regs;
    logic [NREG-1:0][DATA_WIDTH-1:0]   bank;
    logic [NSTORE-1:0]                 wr_sel;
    logic [NPORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NPORTS-1:0][DATA_WIDTH-1:0] rd_data;

    // The PC address has no decoder line, so writes aimed at it fall away.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NSTORE; i++)
            wr_sel[i] = LE && (RW == ADDR_WIDTH'(i));
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NSTORE; i++) begin
            if (RST)
                regs[i] <= '0;
            else if (wr_sel[i])
                regs[i] <= PW;
        end
    end

    // PROGCOUNT occupies the top slot so reads of it are live, not stored.
    assign bank    = {PROGCOUNT, regs};
    assign rd_addr = {RC, RB, RA};

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_rd
            regfile_rd_port #(
                .ADDR_WIDTH(ADDR_WIDTH),
                .DATA_WIDTH(DATA_WIDTH)
            ) u_rd (
                .bank(bank),
                .addr(rd_addr[p]),
                .data(rd_data[p])
            );
        end
    endgenerate

    assign PA = rd_data[0];
    assign PB = rd_data[1];
    assign PC = rd_data[2];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: array model checked every cycle plus literal pins.
`timescale 1ns/100ps
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra, rb, rc, rw;
    logic [31:0] pw, progcount;
    logic        le;
    logic [31:0] pa, pb, pc;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [15];
    bit          model_valid = 1'b0;

    always #2 clk = ~clk;

    register_file dut (
        .CLK(clk), .RST(rst), .RA(ra), .RB(rb), .RC(rc), .RW(rw),
        .PW(pw), .LE(le), .PROGCOUNT(progcount), .PA(pa), .PB(pb), .PC(pc)
    );

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        return (a == 4'd15) ? progcount : model[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural rules: reset clears all, otherwise one enabled write below 15.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) model[i] = 32'd0;
            model_valid = 1'b1;
        end else if (le && rw != 4'd15) begin
            model[rw] = pw;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_PA", pa, exp_rd(ra));
            chk("cyc_PB", pb, exp_rd(rb));
            chk("cyc_PC", pc, exp_rd(rc));
        end
    end

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; le = 1'b1; rw = 4'd3; pw = 32'd99;
        ra = 4'd3; rb = 4'd15; rc = 4'd0; progcount = 32'd0;
        #1;

        // Reset has priority over the simultaneous write
        edge1;
        chk("rst_PA", pa, 32'd0);
        chk("rst_PB_pc", pb, 32'd0);
        rst = 1'b0;
        edge1;
        chk("post_rst_wr", pa, 32'd99);

        // Sequential fill, ending on the ignored write to R15
        progcount = 32'd32; pw = 32'd20; rw = 4'd0; ra = 4'd0; rb = 4'd15; rc = 4'd14;
        #0.5;
        chk("fill_PB_init", pb, 32'd32);
        for (int k = 0; k < 16; k++) begin
            edge1;
            if (k < 15) chk("fill_PA", pa, 32'(20 + k));
            if (k < 15) begin
                pw = pw + 1; rw = rw + 1; ra = ra + 1;
                rb = rb + 1; rc = rc + 1; progcount = progcount + 1;
            end
        end
        chk("pc_alias_PA", pa, 32'd47);
        chk("wrap_PB_R14", pb, 32'd34);
        chk("wrap_PC_R13", pc, 32'd33);
        progcount = 32'd100;
        #0.5;
        chk("pc_live_PA", pa, 32'd100);

        // Load enable gating
        le = 1'b1; rw = 4'd5; pw = 32'hDEADBEEF; ra = 4'd0; rb = 4'd1; rc = 4'd2;
        edge1;
        le = 1'b0; pw = 32'h12345678; ra = 4'd5; rb = 4'd5; rc = 4'd5;
        for (int k = 0; k < 3; k++) begin
            edge1;
            chk("le0_PA", pa, 32'hDEADBEEF);
            chk("le0_PB", pb, 32'hDEADBEEF);
            chk("le0_PC", pc, 32'hDEADBEEF);
        end

        // Read during write: old value before edge, new value right after
        le = 1'b1; rw = 4'd7; pw = 32'd1;
        edge1;
        pw = 32'd2;
        ra = 4'd7; rb = 4'd7; rc = 4'd7;
        #0.5;
        chk("rdw_pre_PA", pa, 32'd1);
        chk("rdw_pre_PB", pb, 32'd1);
        chk("rdw_pre_PC", pc, 32'd1);
        edge1;
        chk("rdw_post_PA", pa, 32'd2);
        chk("rdw_post_PB", pb, 32'd2);
        chk("rdw_post_PC", pc, 32'd2);

        // Fill everything, then reset with a competing write
        for (int i = 0; i < 15; i++) begin
            rw = 4'(i); pw = 32'(i * 3 + 1); le = 1'b1;
            edge1;
        end
        ra = 4'd14; #0.5;
        chk("fill2_R14", pa, 32'd43);
        rst = 1'b1; le = 1'b1; rw = 4'd2; pw = 32'hFF; progcount = 32'h0000_1234;
        edge1;
        rst = 1'b0; le = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i); rc = 4'd2;
            #0.5;
            chk("rst2_PA", pa, (i == 15) ? 32'h0000_1234 : 32'd0);
            edge1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
